// File: rtl/obstacle_scheduler_if.sv
// Shared VGA plot port between the obstacle scheduler and the top-level arbiter.
//
// Handshake: the scheduler raises sched_req and keeps it high for its whole pass.
// The arbiter raises sched_gnt when the port is free and must keep it high until
// sched_req falls. The scheduler samples sched_gnt only while waiting for it.
// plot is a one-cycle strobe. plot_x, plot_y and plot_colour are valid only while
// plot is high. There is no back-pressure on plot strobes.
interface obstacle_scheduler_if;
   logic       sched_req;
   logic       sched_gnt;
   logic       plot;
   logic [7:0] plot_x;
   logic [6:0] plot_y;
   logic [2:0] plot_colour;

   modport master (
      output sched_req, plot, plot_x, plot_y, plot_colour,
      input  sched_gnt
   );

   modport slave (
      input  sched_req, plot, plot_x, plot_y, plot_colour,
      output sched_gnt
   );
endinterface

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: paces obstacle moves from the frame tick and walks every
// obstacle segment to emit erase / move / redraw plot commands on the shared
// VGA port.
module obstacle_scheduler #(
   parameter int         N_OBS      = 2,
   parameter int         MOVE_DIV   = 4,
   parameter logic [2:0] OBS_COLOUR = 3'b100,
   parameter logic [2:0] BG_COLOUR  = 3'b000
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 frame_tick,
   input  logic                 enable,
   input  logic                 endgame,
   input  logic [8*N_OBS-1:0]   obs_x,
   input  logic [7*N_OBS-1:0]   obs_y,
   output logic [N_OBS-1:0]     move,
   output logic [3:0]           v,
   output logic [1:0]           obs_sel,
   output logic                 busy,
   output logic                 overrun,
   output logic [2:0]           state_dbg,
   obstacle_scheduler_if.master vga
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_GNT = 3'd1,
      S_ERASE    = 3'd2,
      S_MOVE     = 3'd3,
      S_DRAW     = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   localparam int         DIV_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);
   localparam logic [1:0] LAST_SEL = 2'(N_OBS - 1);

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               init_pending_q, init_pending_d;
   logic               draw_only_q, draw_only_d;
   logic [1:0]         obs_sel_q, obs_sel_d;
   logic [3:0]         v_q, v_d;
   logic               plot_q, plot_d;
   logic [7:0]         plot_x_q, plot_x_d;
   logic [6:0]         plot_y_q, plot_y_d;
   logic [2:0]         plot_colour_q, plot_colour_d;
   logic [N_OBS-1:0]   move_q, move_d;
   logic               sched_req_q, sched_req_d;
   logic               overrun_q, overrun_d;

   logic [7:0]         sel_x;
   logic [6:0]         sel_y;
   logic               last_idx;

   // Pick the column and row of the segment currently presented to the obstacles.
   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int k = 0; k < N_OBS; k++) begin
         if (obs_sel_q == 2'(k)) begin
            sel_x = obs_x[8*k +: 8];
            sel_y = obs_y[7*k +: 7];
         end
      end
   end

   assign last_idx = (obs_sel_q == LAST_SEL) && (v_q == 4'd9);

   // Next-state logic for the pass sequencer, divider and registered outputs.
   always_comb begin
      state_d        = state_q;
      div_d          = div_q;
      init_pending_d = init_pending_q;
      draw_only_d    = draw_only_q;
      obs_sel_d      = obs_sel_q;
      v_d            = v_q;
      plot_d         = 1'b0;
      plot_x_d       = plot_x_q;
      plot_y_d       = plot_y_q;
      plot_colour_d  = plot_colour_q;
      overrun_d      = overrun_q;

      // A tick that lands mid-pass (DONE included) is lost; remember that it happened.
      if (frame_tick && (state_q != S_IDLE)) overrun_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (init_pending_q) begin
               // First display after reset: draw obstacles where they are, no move.
               if (enable) begin
                  state_d        = S_WAIT_GNT;
                  draw_only_d    = 1'b1;
                  init_pending_d = 1'b0;
               end
            end else if (frame_tick && enable && !endgame) begin
               if (div_q == DIV_LAST) begin
                  div_d       = '0;
                  state_d     = S_WAIT_GNT;
                  draw_only_d = 1'b0;
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
         end
         S_WAIT_GNT: begin
            if (vga.sched_gnt) begin
               state_d   = draw_only_q ? S_DRAW : S_ERASE;
               obs_sel_d = '0;
               v_d       = '0;
            end
         end
         S_ERASE, S_DRAW: begin
            // Plot the segment presented this cycle; it appears one cycle later.
            plot_d        = 1'b1;
            plot_x_d      = sel_x;
            plot_y_d      = sel_y;
            plot_colour_d = (state_q == S_ERASE) ? BG_COLOUR : OBS_COLOUR;
            if (last_idx) begin
               state_d = (state_q == S_ERASE) ? S_MOVE : S_DONE;
            end else if (v_q == 4'd9) begin
               v_d       = '0;
               obs_sel_d = obs_sel_q + 2'd1;
            end else begin
               v_d = v_q + 4'd1;
            end
         end
         S_MOVE: begin
            // Obstacles step on the edge leaving MOVE, so the redraw sees new rows.
            state_d   = S_DRAW;
            obs_sel_d = '0;
            v_d       = '0;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      move_d      = (state_d == S_MOVE) ? '1 : '0;
      sched_req_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q        <= S_IDLE;
         div_q          <= '0;
         init_pending_q <= 1'b1;
         draw_only_q    <= 1'b0;
         obs_sel_q      <= '0;
         v_q            <= '0;
         plot_q         <= 1'b0;
         plot_x_q       <= '0;
         plot_y_q       <= '0;
         plot_colour_q  <= '0;
         move_q         <= '0;
         sched_req_q    <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         div_q          <= div_d;
         init_pending_q <= init_pending_d;
         draw_only_q    <= draw_only_d;
         obs_sel_q      <= obs_sel_d;
         v_q            <= v_d;
         plot_q         <= plot_d;
         plot_x_q       <= plot_x_d;
         plot_y_q       <= plot_y_d;
         plot_colour_q  <= plot_colour_d;
         move_q         <= move_d;
         sched_req_q    <= sched_req_d;
         overrun_q      <= overrun_d;
      end
   end

   assign move            = move_q;
   assign v               = v_q;
   assign obs_sel         = obs_sel_q;
   assign busy            = sched_req_q;
   assign overrun         = overrun_q;
   assign state_dbg       = state_q;
   assign vga.sched_req   = sched_req_q;
   assign vga.plot        = plot_q;
   assign vga.plot_x      = plot_x_q;
   assign vga.plot_y      = plot_y_q;
   assign vga.plot_colour = plot_colour_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler with a two-obstacle behavioural model.
module tb_obstacle_scheduler;
   localparam int N_OBS = 2;
   localparam logic [7:0] X0 = 8'd20;
   localparam logic [7:0] X1 = 8'd90;

   logic                 clock = 1'b0;
   logic                 resetn = 1'b0;
   logic                 frame_tick = 1'b0;
   logic                 enable = 1'b0;
   logic                 endgame = 1'b0;
   logic [8*N_OBS-1:0]   obs_x;
   logic [7*N_OBS-1:0]   obs_y;
   logic [N_OBS-1:0]     move;
   logic [3:0]           v;
   logic [1:0]           obs_sel;
   logic                 busy;
   logic                 overrun;
   logic [2:0]           state_dbg;
   logic [6:0]           top [N_OBS];
   logic [20:0]          obs_vec;
   logic [20:0]          exp_vec;
   int                   checks = 0;
   int                   errors = 0;

   obstacle_scheduler_if vga ();

   obstacle_scheduler #(
      .N_OBS(N_OBS), .MOVE_DIV(4), .OBS_COLOUR(3'b100), .BG_COLOUR(3'b000)
   ) dut (
      .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .enable(enable),
      .endgame(endgame), .obs_x(obs_x), .obs_y(obs_y), .move(move), .v(v),
      .obs_sel(obs_sel), .busy(busy), .overrun(overrun), .state_dbg(state_dbg),
      .vga(vga)
   );

   // Clock and obstacle model: each obstacle's top row steps down on its move pulse.
   always #5 clock = ~clock;

   always @(posedge clock) begin
      for (int k = 0; k < N_OBS; k++) begin
         if (!resetn) top[k] <= 7'd0;
         else if (move[k]) top[k] <= top[k] + 7'd1;
      end
   end

   assign obs_x = {X1, X0};
   for (genvar k = 0; k < N_OBS; k++) begin : g_obs
      assign obs_y[7*k +: 7] = top[k] + 7'(v);
   end

   assign obs_vec = {vga.plot, vga.plot_x, vga.plot_y, vga.plot_colour, move};

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      enable = 1'b0;
      vga.sched_gnt = 1'b0;
      step();
      step();
      checks++;
      if ({vga.sched_req, obs_vec, v, obs_sel, busy, overrun} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got req=%b vec=%h v=%h sel=%h busy=%b ovr=%b exp all 0",
                  vga.sched_req, obs_vec, v, obs_sel, busy, overrun);
      end
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (vga.sched_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_enable got req=%b exp 0", vga.sched_req);
      end
   endtask

   task automatic test_init_draw();
      enable = 1'b1;
      vga.sched_gnt = 1'b1;
      step();
      checks++;
      if ({vga.sched_req, busy, vga.plot} !== 3'b110) begin
         errors++;
         $display("FAIL init_req got %b exp 110", {vga.sched_req, busy, vga.plot});
      end
      step();
      checks++;
      if ({vga.sched_req, vga.plot} !== 2'b10) begin
         errors++;
         $display("FAIL init_first got %b exp 10", {vga.sched_req, vga.plot});
      end
      for (int i = 0; i < 20; i++) begin
         step();
         exp_vec = {1'b1, (i < 10) ? X0 : X1, 7'(i % 10), 3'b100, 2'b00};
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL init_scan[%0d] got %h exp %h", i, obs_vec, exp_vec);
         end
      end
      step();
      checks++;
      if ({vga.sched_req, busy, vga.plot, move} !== 5'b0) begin
         errors++;
         $display("FAIL init_end got %b exp 00000", {vga.sched_req, busy, vga.plot, move});
      end
   endtask

   task automatic test_move_pass();
      for (int t = 0; t < 3; t++) begin
         pulse_tick();
         step();
         checks++;
         if (vga.sched_req !== 1'b0) begin
            errors++;
            $display("FAIL move_div_tick%0d got req=%b exp 0", t, vga.sched_req);
         end
      end
      pulse_tick();
      checks++;
      if ({vga.sched_req, vga.plot} !== 2'b10) begin
         errors++;
         $display("FAIL move_start got %b exp 10", {vga.sched_req, vga.plot});
      end
      step();
      for (int i = 0; i < 20; i++) begin
         step();
         exp_vec = {1'b1, (i < 10) ? X0 : X1, 7'(i % 10), 3'b000, (i == 19) ? 2'b11 : 2'b00};
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL erase_scan[%0d] got %h exp %h", i, obs_vec, exp_vec);
         end
      end
      step();
      checks++;
      if ({vga.sched_req, vga.plot, move} !== 4'b1000) begin
         errors++;
         $display("FAIL move_gap got %b exp 1000", {vga.sched_req, vga.plot, move});
      end
      for (int i = 0; i < 20; i++) begin
         step();
         exp_vec = {1'b1, (i < 10) ? X0 : X1, 7'(1 + i % 10), 3'b100, 2'b00};
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL redraw_scan[%0d] got %h exp %h", i, obs_vec, exp_vec);
         end
      end
      step();
      checks++;
      if ({vga.sched_req, busy, vga.plot} !== 3'b000) begin
         errors++;
         $display("FAIL move_end got %b exp 000", {vga.sched_req, busy, vga.plot});
      end
   endtask

   task automatic test_grant_wait();
      int n;
      vga.sched_gnt = 1'b0;
      for (int t = 0; t < 4; t++) pulse_tick();
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ({vga.sched_req, vga.plot} !== 2'b10) begin
            errors++;
            $display("FAIL gnt_wait[%0d] got %b exp 10", i, {vga.sched_req, vga.plot});
         end
      end
      vga.sched_gnt = 1'b1;
      step();
      n = 0;
      checks++;
      if ({vga.sched_req, vga.plot} !== 2'b10) begin
         errors++;
         $display("FAIL gnt_sampled got %b exp 10", {vga.sched_req, vga.plot});
      end
      step();
      n++;
      exp_vec = {1'b1, X0, 7'd1, 3'b000, 2'b00};
      checks++;
      if (obs_vec !== exp_vec) begin
         errors++;
         $display("FAIL gnt_first_plot got %h exp %h", obs_vec, exp_vec);
      end
      while (busy && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (n !== 42) begin
         errors++;
         $display("FAIL gnt_pass_len got %0d exp 42", n);
      end
   endtask

   task automatic test_overrun();
      int n;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear got %b exp 0", overrun);
      end
      for (int t = 0; t < 4; t++) pulse_tick();
      for (int i = 0; i < 25; i++) step();
      checks++;
      if (state_dbg !== 3'd4) begin
         errors++;
         $display("FAIL overrun_in_draw got state=%0d exp 4", state_dbg);
      end
      pulse_tick();
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_set got %b exp 1", overrun);
      end
      n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      checks++;
      if ({busy, overrun} !== 2'b01) begin
         errors++;
         $display("FAIL overrun_sticky got busy=%b ovr=%b exp 0 1", busy, overrun);
      end
      for (int t = 0; t < 3; t++) begin
         pulse_tick();
         checks++;
         if (vga.sched_req !== 1'b0) begin
            errors++;
            $display("FAIL overrun_div_tick%0d got req=%b exp 0", t, vga.sched_req);
         end
      end
      pulse_tick();
      checks++;
      if (vga.sched_req !== 1'b1) begin
         errors++;
         $display("FAIL overrun_next_pass got req=%b exp 1", vga.sched_req);
      end
      n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      checks++;
      if ({busy, overrun} !== 2'b01) begin
         errors++;
         $display("FAIL overrun_after_pass got busy=%b ovr=%b exp 0 1", busy, overrun);
      end
   endtask

   task automatic test_endgame();
      int n;
      for (int t = 0; t < 2; t++) pulse_tick();
      endgame = 1'b1;
      for (int t = 0; t < 8; t++) begin
         pulse_tick();
         checks++;
         if ({vga.sched_req, move} !== 3'b000) begin
            errors++;
            $display("FAIL endgame_tick%0d got %b exp 000", t, {vga.sched_req, move});
         end
      end
      endgame = 1'b0;
      pulse_tick();
      checks++;
      if (vga.sched_req !== 1'b0) begin
         errors++;
         $display("FAIL endgame_resume3 got req=%b exp 0", vga.sched_req);
      end
      pulse_tick();
      checks++;
      if (vga.sched_req !== 1'b1) begin
         errors++;
         $display("FAIL endgame_resume4 got req=%b exp 1", vga.sched_req);
      end
      n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL endgame_pass_end got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_reset_mid_pass();
      for (int t = 0; t < 4; t++) pulse_tick();
      step();
      for (int i = 0; i < 7; i++) step();
      checks++;
      if (state_dbg !== 3'd2) begin
         errors++;
         $display("FAIL midreset_in_erase got state=%0d exp 2", state_dbg);
      end
      resetn = 1'b0;
      step();
      checks++;
      if ({vga.sched_req, obs_vec, v, obs_sel, busy, overrun} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got req=%b vec=%h v=%h sel=%h busy=%b ovr=%b exp all 0",
                  vga.sched_req, obs_vec, v, obs_sel, busy, overrun);
      end
      resetn = 1'b1;
      step();
      checks++;
      if ({vga.sched_req, vga.plot, move} !== 4'b1000) begin
         errors++;
         $display("FAIL midreset_req got %b exp 1000", {vga.sched_req, vga.plot, move});
      end
      step();
      for (int i = 0; i < 20; i++) begin
         step();
         exp_vec = {1'b1, (i < 10) ? X0 : X1, 7'(i % 10), 3'b100, 2'b00};
         checks++;
         if (obs_vec !== exp_vec) begin
            errors++;
            $display("FAIL midreset_scan[%0d] got %h exp %h", i, obs_vec, exp_vec);
         end
      end
      step();
      checks++;
      if ({vga.sched_req, busy, vga.plot} !== 3'b000) begin
         errors++;
         $display("FAIL midreset_end got %b exp 000", {vga.sched_req, busy, vga.plot});
      end
   endtask

   // Test sequence and final report.
   initial begin
      vga.sched_gnt = 1'b0;
      test_reset();
      test_init_draw();
      test_move_pass();
      test_grant_wait();
      test_overrun();
      test_endgame();
      test_reset_mid_pass();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Sequences the vertical obstacle blocks: decides when they advance, and walks their 10 segments to generate VGA plot commands.
- Each move is a complete pass: erase old positions in background colour, pulse the obstacles' move inputs, redraw in obstacle colour.
- Requests the shared VGA plot port from the top-level arbiter (req/gnt) so obstacle plots never collide with snake/food drawing.

Parameters:
- N_OBS, 2, number of obstacle instances driven (1..4).
- MOVE_DIV, 4, frame ticks per obstacle move (>=1).
- OBS_COLOUR, 3'b100, colour for drawn segments.
- BG_COLOUR, 3'b000, colour for erased segments.

Ports:
- clock  input  1  system clock.
- resetn  input  1  synchronous active-low reset.
- frame_tick  input  1  one-cycle pulse per frame.
- enable  input  1  obstacles displayed/active (display_v from top FSM).
- endgame  input  1  game over; freezes obstacle motion.
- sched_gnt  input  1  VGA port grant from arbiter.
- obs_x  input  8*N_OBS  obstacle k column at bits [8k+7:8k].
- obs_y  input  7*N_OBS  obstacle k y of segment v, bits [7k+6:7k] (combinational from v).
- sched_req  output  1  VGA port request.
- move  output  N_OBS  per-obstacle move pulse.
- v  output  4  segment index to all obstacles.
- obs_sel  output  2  obstacle being read.
- plot  output  1  plot strobe to VGA adapter.
- plot_x  output  8  plot column.
- plot_y  output  7  plot row.
- plot_colour  output  3  plot colour.
- busy  output  1  high whenever state != IDLE.
- overrun  output  1  sticky: frame_tick arrived while busy.

Behaviour:
- Reset is synchronous (resetn low at a clock edge). All outputs go to 0, state IDLE, divider 0, init_pending=1. Applies mid-pass: the pass is abandoned with no further plots or move.
- States: IDLE, WAIT_GNT, ERASE, MOVE, DRAW, DONE.
- IDLE, init_pending=1, enable=1: go WAIT_GNT, draw_only=1, clear init_pending.
- IDLE, init_pending=0: a frame_tick with enable=1 and endgame=0 advances the divider.
  - If divider == MOVE_DIV-1: divider wraps to 0 and the FSM goes WAIT_GNT with draw_only=0.
  - Otherwise: divider+1.
  - frame_tick with enable=0 or endgame=1 is ignored (divider unchanged).
- WAIT_GNT: sched_req=1. Stays until sched_gnt is sampled high, then goes to ERASE, or to DRAW if draw_only.
- sched_req stays high from WAIT_GNT through DONE inclusive. sched_gnt is sampled only in WAIT_GNT; the arbiter must hold it until req falls.
- ERASE and DRAW scan the index (obs_sel, v) from (0,0) to (N_OBS-1,9), seg-major within obstacle, one index per cycle: 10*N_OBS cycles.
- plot, plot_x, plot_y and plot_colour are registered. They reflect the index presented the previous cycle: plot_x = obs_x slice, plot_y = obs_y slice, colour BG (ERASE) or OBS (DRAW).
- The last plot of each scan therefore appears in the following state (MOVE or DONE).
- MOVE: one cycle with move = all ones, then DRAW. Obstacles update on the edge leaving MOVE, so DRAW reads the new positions.
- DONE: one cycle; req drops at the exit edge; then IDLE.
- A full pass takes 20*N_OBS+2 cycles after grant; a draw-only pass takes 10*N_OBS+1.
- frame_tick while busy=1 (including DONE): tick dropped, divider unchanged, overrun set. overrun clears only on reset.
- enable or endgame changing mid-pass: the pass completes normally.
- obs_sel and v hold their last value outside scans. plot is 0 outside scan output cycles.

Test Plan:
1. Reset, enable=1, gnt tied 1 -> req rises the next cycle; 20 plot cycles with colour 3'b100 and y = 0..9 per obstacle; move never pulses; busy falls after DONE.
2. After init, 4 frame_ticks -> only the 4th starts a pass: 20 plots colour 0 at old y 0..9, one-cycle move=2'b11, then 20 plots at y 1..10.
3. sched_gnt held low 5 cycles -> req high and plot=0 throughout; first plot appears 2 cycles after gnt is sampled.
4. frame_tick during DRAW -> overrun=1 stays; the next 4 idle ticks are still needed for the next pass.
5. endgame=1, 8 frame_ticks -> no req, no move, divider frozen; clearing endgame resumes counting from the stored value.
6. resetn low during ERASE cycle 7 -> all outputs 0 the next cycle, no move pulse; with enable=1, draw-only init pass repeats.
